// File: rtl/i2s_pkg.sv
// i2s_pkg -- shared constants and helpers for the I2S frame master/transmitter.
//   FRAME_BITS / HALF_BITS : 64-bit stereo frame, 32 bit slots per channel.
//   POSN_W                 : width of the frame position counter.
//   LEFT_MSB_POSN / RIGHT_MSB_POSN : frame positions carrying each channel's MSB.
//   slot_offset()          : distance of a frame position from its channel's MSB slot.
package i2s_pkg;

  localparam int FRAME_BITS     = 64;
  localparam int HALF_BITS      = 32;
  localparam int POSN_W         = 6;
  localparam int LEFT_MSB_POSN  = 1;
  localparam int RIGHT_MSB_POSN = 33;

  typedef logic [POSN_W-1:0] posn_t;

  // Offset of posn from the MSB slot of the channel it belongs to. Positions
  // before the MSB slot (0 and 32) wrap to 63, so they never look like data.
  function automatic posn_t slot_offset(input posn_t posn);
    if (posn >= posn_t'(HALF_BITS))
      return posn - posn_t'(RIGHT_MSB_POSN);
    else
      return posn - posn_t'(LEFT_MSB_POSN);
  endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// i2s_clkgen -- I2S frame timing master: prescaler, bit clock, word select,
// frame position and receiver sample strobe. Usable on its own by
// receiver-only designs.
// Ports:
//   ck, rst       : system clock, asynchronous active-high reset
//   sck           : bit clock, toggles every DIV ck
//   ws            : word select (0 = left half, 1 = right half), registered
//   frame_posn    : bit position in the 64-bit frame, advances on sck fall
//   sample        : one-ck strobe in the cycle sck goes high
//   fall          : combinational strobe, high in the cycle before sck falls
//   frame_start   : combinational strobe, high in the cycle before posn wraps 63->0
module i2s_clkgen
  import i2s_pkg::*;
#(
  parameter int DIV = 2
) (
  input  logic              ck,
  input  logic              rst,
  output logic              sck,
  output logic              ws,
  output logic [POSN_W-1:0] frame_posn,
  output logic              sample,
  output logic              fall,
  output logic              frame_start
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0]  div_cnt;
  logic              tc;
  logic [POSN_W-1:0] posn_next;

  assign tc          = (div_cnt == CNT_LAST);
  assign fall        = tc & sck;
  assign frame_start = fall && (frame_posn == POSN_W'(FRAME_BITS - 1));
  assign posn_next   = frame_posn + POSN_W'(1);

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      div_cnt    <= '0;
      sck        <= 1'b0;
      ws         <= 1'b0;
      frame_posn <= '0;
      sample     <= 1'b0;
    end else begin
      sample <= 1'b0;
      if (tc) begin
        div_cnt <= '0;
        sck     <= ~sck;
        if (!sck) begin
          sample <= 1'b1;
        end else begin
          frame_posn <= posn_next;
          ws         <= (posn_next >= POSN_W'(HALF_BITS));
        end
      end else begin
        div_cnt <= div_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/i2s_tx.sv
// i2s_tx -- I2S frame master and serial transmitter (standard I2S alignment,
// 64-bit stereo frame, MSB one bit after the ws transition).
// Ports:
//   ck, rst              : system clock, asynchronous active-high reset
//   in_valid / in_ready  : handshake into a one-deep holding register
//   in_left / in_right   : BITS-wide two's-complement sample pair
//   sck, ws, sd          : I2S bit clock, word select, serial data
//   frame_posn, sample   : frame timing shared with co-located receivers
//   underflow            : one-ck pulse when a frame starts with no pair held
// Parameters: BITS (2..31) sample width, DIV (>=1) ck per sck half period.
// Build option: define I2S_TX_REPEAT_EN to repeat the previous pair on
// underflow instead of sending zeros.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int BITS = 16,
  parameter int DIV  = 2
) (
  input  logic              ck,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BITS-1:0]   in_left,
  input  logic [BITS-1:0]   in_right,
  output logic              sck,
  output logic              ws,
  output logic              sd,
  output logic [POSN_W-1:0] frame_posn,
  output logic              sample,
  output logic              underflow
);

  logic            fall;
  logic            frame_start;
  logic [BITS-1:0] hold_l;
  logic [BITS-1:0] hold_r;
  logic            hold_full;
  logic [BITS-1:0] shift_l;
  logic [BITS-1:0] shift_r;
  logic            armed;      // cleared by reset so the first wrap never flags underflow
  posn_t           posn_next;
  posn_t           offset;
  logic [BITS-1:0] word;
  logic [BITS-1:0] shifted;
  logic            sd_next;

  i2s_clkgen #(.DIV(DIV)) u_clkgen (
    .ck          (ck),
    .rst         (rst),
    .sck         (sck),
    .ws          (ws),
    .frame_posn  (frame_posn),
    .sample      (sample),
    .fall        (fall),
    .frame_start (frame_start)
  );

  // Serial bit for the position that becomes current at the next sck fall.
  // At the frame-start fall the new position is 0, which is never a data slot,
  // so the shift registers loading in that same cycle is harmless.
  always_comb begin
    posn_next = frame_posn + posn_t'(1);
    offset    = slot_offset(posn_next);
    word      = posn_next[POSN_W-1] ? shift_r : shift_l;
    shifted   = '0;
    sd_next   = 1'b0;
    if (offset < posn_t'(BITS)) begin
      shifted = word >> (posn_t'(BITS - 1) - offset);
      sd_next = shifted[0];
    end
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      hold_l    <= '0;
      hold_r    <= '0;
      hold_full <= 1'b0;
      in_ready  <= 1'b1;
      shift_l   <= '0;
      shift_r   <= '0;
      sd        <= 1'b0;
      underflow <= 1'b0;
      armed     <= 1'b0;
    end else begin
      underflow <= 1'b0;

      if (fall)
        sd <= sd_next;

      if (frame_start) begin
        armed <= 1'b1;
        if (hold_full) begin
          shift_l <= hold_l;
          shift_r <= hold_r;
        end else begin
          underflow <= armed;
`ifdef I2S_TX_REPEAT_EN
          // Keep the last pair, except on the unarmed first wrap which sends zeros.
          if (!armed) begin
            shift_l <= '0;
            shift_r <= '0;
          end
`else
          shift_l <= '0;
          shift_r <= '0;
`endif
        end
      end

      // A transfer needs an empty holding register, so it never coincides with
      // the frame-start unload; a transfer in that cycle fills hold for the next frame.
      if (in_valid && in_ready) begin
        hold_l    <= in_left;
        hold_r    <= in_right;
        hold_full <= 1'b1;
        in_ready  <= 1'b0;
      end else if (frame_start && hold_full) begin
        hold_full <= 1'b0;
        in_ready  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
module tb_i2s_tx;
  localparam int BITS = 16;
  localparam int DIV  = 2;

  logic        ck = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_left = '0;
  logic [15:0] in_right = '0;
  logic        in_ready, sck, ws, sd, sample, underflow;
  logic [5:0]  frame_posn;

  always #5 ck = ~ck;

  i2s_tx #(.BITS(BITS), .DIV(DIV)) dut (
    .ck(ck), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_left(in_left), .in_right(in_right), .sck(sck), .ws(ws), .sd(sd),
    .frame_posn(frame_posn), .sample(sample), .underflow(underflow)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge ck) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Scoreboard entry: expected 64 sd bits of one frame (posn 0 first) and
  // whether the wrap that starts this frame must flag underflow.
  typedef struct packed {
    logic [63:0] data;
    logic        uf;
  } exp_t;
  exp_t sb[$];
  logic mon_en = 1'b0;

  // Receiver-style monitor: captures sd on every sample strobe.
  logic [63:0] cap = '0;
  logic [63:0] wcap = '0;
  int          nbits = 0;
  logic [5:0]  posn_prev = '0;
  int          uf_cycles = 0;
  exp_t        e;

  always @(negedge ck) begin
    if (rst) begin
      nbits = 0; cap = '0; wcap = '0; posn_prev = '0;
    end else if (mon_en) begin
      if (underflow) uf_cycles++;
      if (frame_posn == 6'd0 && posn_prev == 6'd63) begin
        if (sb.size() == 0) check("sb_empty_at_wrap", 64'd1, 64'd0);
        else check("underflow_at_wrap", {63'd0, underflow}, {63'd0, sb[0].uf});
        check("in_ready_after_start", {63'd0, in_ready}, 64'd1);
      end
      if (sample) begin
        cap  = {cap[62:0], sd};
        wcap = {wcap[62:0], ws};
        nbits++;
        if (frame_posn == 6'd63) begin
          check("frame_bits", 64'(nbits), 64'd64);
          if (sb.size() == 0) check("sb_empty_at_end", 64'd1, 64'd0);
          else begin
            e = sb.pop_front();
            $display("frame done: sd=%h ws=%h", cap, wcap);
            check("frame_sd", cap, e.data);
            check("frame_ws", wcap, 64'h00000000_FFFFFFFF);
          end
          nbits = 0;
        end
      end
      posn_prev = frame_posn;
    end
  end

  // Cadence instances with DIV=1 and DIV=3.
  for (genvar gi = 0; gi < 2; gi++) begin : g_cad
    localparam int D = (gi == 0) ? 1 : 3;
    logic       c_rdy, c_sck, c_ws, c_sd, c_sample, c_uf;
    logic [5:0] c_posn;
    int         last_s = -1;
    int         last_w = -1;
    logic [5:0] pp = '0;
    logic       pws = 1'b0;

    i2s_tx #(.BITS(16), .DIV(D)) u_cad (
      .ck(ck), .rst(rst), .in_valid(1'b0), .in_ready(c_rdy),
      .in_left(16'h0000), .in_right(16'h0000), .sck(c_sck), .ws(c_ws), .sd(c_sd),
      .frame_posn(c_posn), .sample(c_sample), .underflow(c_uf)
    );

    always @(negedge ck) begin
      if (rst) begin
        last_s = -1; last_w = -1; pp = '0; pws = 1'b0;
      end else if (mon_en) begin
        if (c_sample) begin
          if (last_s >= 0) check($sformatf("sample_period_div%0d", D), 64'(cyc - last_s), 64'(2 * D));
          last_s = cyc;
        end
        if (c_posn == 6'd0 && pp == 6'd63) begin
          if (last_w >= 0) begin
            $display("div%0d frame length %0d ck", D, cyc - last_w);
            check($sformatf("frame_len_div%0d", D), 64'(cyc - last_w), 64'(128 * D));
          end
          last_w = cyc;
        end
        if (c_ws != pws)
          check($sformatf("ws_toggle_div%0d", D), {57'd0, c_ws, c_posn},
                c_ws ? {57'd0, 1'b1, 6'd32} : 64'd0);
        pp = c_posn; pws = c_ws;
      end
    end
  end

  // Directed vectors: expected frame = {0, left, 15 zeros, 0, right, 15 zeros}.
  logic [15:0] vl [5];
  logic [15:0] vr [5];
  logic [63:0] vexp [5];

  task automatic push(input logic [15:0] l, input logic [15:0] r);
    int n = 0;
    @(negedge ck);
    while (!in_ready && n < 2000) begin
      @(negedge ck);
      n++;
    end
    if (!in_ready) begin
      check("push_timeout", 64'd0, 64'd1);
    end else begin
      in_valid = 1'b1; in_left = l; in_right = r;
      @(negedge ck);
      in_valid = 1'b0;
      $display("push left=%h right=%h", l, r);
      check("in_ready_drop", {63'd0, in_ready}, 64'd0);
    end
  endtask

  task automatic wait_wrap();
    int n = 0;
    logic [5:0] prev = frame_posn;
    logic seen = 1'b0;
    while (!seen && n < 2000) begin
      @(negedge ck);
      n++;
      if (frame_posn == 6'd0 && prev == 6'd63) seen = 1'b1;
      prev = frame_posn;
    end
    if (!seen) check("wrap_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int n;
    vl[0] = 16'hA5F0; vr[0] = 16'h0F0F; vexp[0] = 64'h52F80000_07878000;
    vl[1] = 16'h1234; vr[1] = 16'h8001; vexp[1] = 64'h091A0000_40008000;
    vl[2] = 16'hFFFF; vr[2] = 16'h0000; vexp[2] = 64'h7FFF8000_00000000;
    vl[3] = 16'h0001; vr[3] = 16'h7FFE; vexp[3] = 64'h00008000_3FFF0000;
    vl[4] = 16'hC3C3; vr[4] = 16'h3C3C; vexp[4] = 64'h61E18000_1E1E0000;

    // Reset state.
    rst = 1'b1;
    repeat (3) @(posedge ck);
    @(negedge ck);
    check("reset_outputs", {52'd0, sck, ws, sd, sample, underflow, in_ready, frame_posn},
          {52'd0, 5'b00000, 1'b1, 6'd0});

    // Frames 0..7 after reset.
    sb.push_back('{data: 64'd0,   uf: 1'b0});
    for (int i = 0; i < 4; i++) sb.push_back('{data: vexp[i], uf: 1'b0});
`ifdef I2S_TX_REPEAT_EN
    sb.push_back('{data: vexp[3], uf: 1'b1});
`else
    sb.push_back('{data: 64'd0,   uf: 1'b1});
`endif
    sb.push_back('{data: vexp[4], uf: 1'b0});
    sb.push_back('{data: 64'd0,   uf: 1'b1});

    rst = 1'b0;
    mon_en = 1'b1;
    n = 0;
    do begin
      @(posedge ck); #1; n++;
    end while (!sample && n < 20);
    check("first_sample_latency", 64'(n), 64'(DIV));

    // Back-to-back pushes fill frames 1..4.
    for (int i = 0; i < 4; i++) push(vl[i], vr[i]);
    wait_wrap();                 // frame 4 starts
    wait_wrap();                 // frame 5 starts empty: underflow
    push(vl[4], vr[4]);          // frame 6
    wait_wrap();
    wait_wrap();                 // frame 7 underflow
    push(vl[0], vr[0]);          // hold full, will be discarded by reset

    n = 0;
    while (frame_posn != 6'd20 && n < 2000) begin
      @(negedge ck); n++;
    end
    check("reach_posn20", {58'd0, frame_posn}, 64'd20);
    check("hold_full_before_reset", {63'd0, in_ready}, 64'd0);
    rst = 1'b1;
    #1;
    check("midframe_reset_outputs", {52'd0, sck, ws, sd, sample, underflow, in_ready, frame_posn},
          {52'd0, 5'b00000, 1'b1, 6'd0});
    sb.delete();
    sb.push_back('{data: 64'd0, uf: 1'b0});
    sb.push_back('{data: 64'd0, uf: 1'b0});
    repeat (2) @(posedge ck);
    @(negedge ck);
    rst = 1'b0;

    n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(posedge ck); n++;
    end
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    mon_en = 1'b0;
    check("underflow_cycles", 64'(uf_cycles), 64'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
